// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and address check for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, DONE = 2'd1, FAULT = 2'd2} fetch_state_e;
  localparam int PC_W = 64;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = PC_W + INSTR_W;
  localparam int INSTR_WORD_BYTES = 4;
  localparam logic [INSTR_W-1:0] INSTR_END_MARKER = 32'h0000_0000;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  // 65-bit sum so addresses near 2^64 cannot wrap into the valid range
  function automatic logic addr_bad(input logic [PC_W-1:0] pc, input int mem_size);
    return (pc[1:0] != 2'b00) || (({1'b0, pc} + 65'd3) > (65'(mem_size) - 65'd1));
  endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: valid/ready handshake carrying {pc, instr} from fetch to IF/ID
interface fetch_if;
  import fetch_pkg::*;
  logic out_valid;
  logic out_ready;
  logic [PC_W-1:0] out_pc;
  logic [INSTR_W-1:0] out_instr;
  modport master(output out_valid, output out_pc, output out_instr, input out_ready);
  modport slave(input out_valid, input out_pc, input out_instr, output out_ready);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush; push and pop may coincide when full
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic [AW:0] count,
  output logic empty,
  output logic full
);
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign empty = r_cnt == '0;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign w_pop = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout = r_mem[r_rd];
  assign count = r_cnt;
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk)
    if (reset && !flush && w_push) r_mem[r_wr] <= din;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: owns the fetch PC, prefetches instruction words and hands them to IF/ID
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int FIFO_DEPTH = 2,
  parameter int MEM_SIZE = 4095
) (
  input  logic clk,
  input  logic reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic done,
  output logic fault,
  fetch_if.master out_if
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e r_state;
  logic [63:0] r_pc;
  logic r_done, r_fault;
  logic w_bad, w_pop, w_push, w_can_push, w_empty, w_full;
  logic [CW-1:0] w_count;
  fetch_entry_t w_head;
  assign imem_addr = r_pc;
  assign done = r_done;
  assign fault = r_fault;
  assign w_bad = addr_bad(r_pc, MEM_SIZE);
  assign w_pop = out_if.out_valid && out_if.out_ready;
  assign w_can_push = !w_full || w_pop;
  assign w_push = r_state == FETCH && !redirect_valid && !w_bad && w_can_push
                  && imem_instr != INSTR_END_MARKER;
  assign out_if.out_valid = !w_empty;
  assign out_if.out_pc = w_empty ? '0 : w_head.pc;
  assign out_if.out_instr = w_empty ? '0 : w_head.instr;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(w_push),
    .pop(w_pop),
    .flush(redirect_valid),
    .din({r_pc, imem_instr}),
    .dout(w_head),
    .count(w_count),
    .empty(w_empty),
    .full(w_full)
  );
  a_full_count: assert property (@(posedge clk) disable iff (!reset)
    w_full == (w_count == CW'(FIFO_DEPTH)));
  // redirect outranks everything except reset, and is the only exit from DONE/FAULT
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH;
      r_pc <= RESET_PC;
      r_done <= 1'b0;
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_state <= FETCH;
      r_pc <= redirect_pc;
      r_done <= 1'b0;
      r_fault <= 1'b0;
    end else if (r_state == FETCH) begin
      if (w_bad) begin
        r_state <= FAULT;
        r_fault <= 1'b1;
      end else if (w_can_push && imem_instr == INSTR_END_MARKER) begin
        r_state <= DONE;
        r_done <= 1'b1;
      end else if (w_can_push) begin
        r_pc <= r_pc + 64'(INSTR_WORD_BYTES);
      end
    end
  end
endmodule
